hese_term_accumulator: RTL and testbench

// - Downstream consumer of the HESE encoder's bit-serial signed-digit stream (term bit + sign bit per cycle).
// - Rebuilds each frame of DIGITS digits, MSB-first, into a two's-complement word: acc = 2*acc + d, d in {-1,0,+1}.
// - Optionally enforces a per-frame nonzero-term budget, which is the term-quantization step.
// - Presents each result through a one-entry valid/ready output buffer.

---
 rtl/hese_term_accumulator.sv | 179 +++++++++++++++++
 tb/tb_hese_term_accumulator.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hese_term_accumulator.sv
// hese_term_accumulator: rebuilds MSB-first signed-digit frames into two's-complement words.
// Define HESE_ACC_TERM_BUDGET_EN to limit the nonzero digits kept per frame to MAX_TERMS.
module hese_term_accumulator #(
  parameter int WIDTH     = 8,
  parameter int MAX_TERMS = 2,
  localparam int ACC_W    = WIDTH + 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    power_on,
  input  logic                    frame_start,
  input  logic                    term_in,
  input  logic                    sign_in,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_truncated,
  output logic                    err_overflow,
  output logic                    err_framing,
  input  logic                    err_clear
);

  localparam int DIGITS = WIDTH + 1;
  localparam int CNT_W  = $clog2(DIGITS + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] acc_base_s;
  logic signed [ACC_W-1:0] acc_nxt_s;
  logic signed [ACC_W-1:0] digit_s;
  logic [CNT_W-1:0]        digit_cnt_r;
  logic [CNT_W-1:0]        cnt_base_s;
  logic [CNT_W-1:0]        digit_cnt_nxt_s;
  logic                    start_s;
  logic                    consume_s;
  logic                    keep_s;
  logic                    frame_done_s;
  logic                    framing_evt_s;
  logic                    overflow_evt_s;
  logic                    load_out_s;

`ifdef HESE_ACC_TERM_BUDGET_EN
  localparam int TERM_W = $clog2(MAX_TERMS + 1);

  logic [TERM_W-1:0] term_cnt_r;
  logic [TERM_W-1:0] term_base_s;
  logic [TERM_W-1:0] term_nxt_s;
  logic              trunc_r;
  logic              trunc_nxt_s;

  // Budget: a nonzero digit past MAX_TERMS still shifts but contributes zero.
  always_comb begin
    term_base_s = start_s ? '0 : term_cnt_r;
    keep_s      = term_in & (term_base_s < TERM_W'(MAX_TERMS));
    term_nxt_s  = term_base_s + TERM_W'(keep_s);
    trunc_nxt_s = (start_s ? 1'b0 : trunc_r) | (term_in & ~keep_s);
  end

  // Term counter and truncation flag of the frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      term_cnt_r <= '0;
      trunc_r    <= 1'b0;
    end else if (consume_s) begin
      term_cnt_r <= term_nxt_s;
      trunc_r    <= trunc_nxt_s;
    end
  end

  // Truncation flag travels with the captured result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_truncated <= 1'b0;
    end else if (load_out_s) begin
      out_truncated <= trunc_nxt_s;
    end
  end
`else
  assign keep_s        = term_in;
  assign out_truncated = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: a frame_start mid-frame restarts without leaving ACC.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (consume_s && !frame_done_s) state_nxt_s = ACC;
        else                            state_nxt_s = IDLE;
      end
      ACC: begin
        if (frame_done_s) state_nxt_s = IDLE;
        else              state_nxt_s = ACC;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath control: which digits are consumed and when a frame completes.
  always_comb begin
    start_s       = power_on & frame_start;
    consume_s     = 1'b0;
    framing_evt_s = 1'b0;
    case (state_r)
      IDLE: begin
        consume_s = start_s;
      end
      ACC: begin
        consume_s     = power_on;
        framing_evt_s = start_s;
      end
      default: begin
        consume_s = 1'b0;
      end
    endcase

    if (keep_s) digit_s = sign_in ? {ACC_W{1'b1}} : ACC_W'(1);
    else        digit_s = '0;

    acc_base_s      = start_s ? '0 : acc_r;
    acc_nxt_s       = (acc_base_s <<< 1) + digit_s;
    cnt_base_s      = start_s ? '0 : digit_cnt_r;
    digit_cnt_nxt_s = cnt_base_s + CNT_W'(1);
    frame_done_s    = consume_s & (digit_cnt_nxt_s == CNT_W'(DIGITS));
    overflow_evt_s  = frame_done_s & out_valid & ~out_ready;
    load_out_s      = frame_done_s & (~out_valid | out_ready);
  end

  // Accumulator and digit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r       <= '0;
      digit_cnt_r <= '0;
    end else if (consume_s) begin
      acc_r       <= acc_nxt_s;
      digit_cnt_r <= digit_cnt_nxt_s;
    end
  end

  // One-entry output buffer; a full, stalled buffer drops the newer result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load_out_s) begin
      out_data  <= acc_nxt_s;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky errors: a same-edge event wins over err_clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_overflow <= 1'b0;
      err_framing  <= 1'b0;
    end else begin
      err_overflow <= overflow_evt_s | (err_overflow & ~err_clear);
      err_framing  <= framing_evt_s | (err_framing & ~err_clear);
    end
  end

endmodule

// File: tb/tb_hese_term_accumulator.sv
// Self-checking bench for hese_term_accumulator: directed frames plus random digit traffic
// compared against a frame-level reference model (honours HESE_ACC_TERM_BUDGET_EN).
module tb_hese_term_accumulator;

  localparam int WIDTH     = 8;
  localparam int MAX_TERMS = 2;
  localparam int DIGITS    = WIDTH + 1;
  localparam int ACC_W     = WIDTH + 2;

  typedef int frame_t[DIGITS];

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    power_on;
  logic                    frame_start;
  logic                    term_in;
  logic                    sign_in;
  logic signed [ACC_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_truncated;
  logic                    err_overflow;
  logic                    err_framing;
  logic                    err_clear;

  int n_checks = 0;
  int n_pass   = 0;
  bit rdy_v    = 1'b1;
  bit clr_v    = 1'b0;

  // reference model state
  int m_dq[$];
  bit m_in_frame;
  int m_data;
  bit m_valid;
  bit m_trunc;
  bit m_err_ov;
  bit m_err_fr;

  hese_term_accumulator #(.WIDTH(WIDTH), .MAX_TERMS(MAX_TERMS)) dut (
    .clk(clk), .reset(reset), .power_on(power_on), .frame_start(frame_start),
    .term_in(term_in), .sign_in(sign_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_truncated(out_truncated), .err_overflow(err_overflow),
    .err_framing(err_framing), .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_dq.delete();
    m_in_frame = 1'b0;
    m_data = 0; m_valid = 1'b0; m_trunc = 1'b0;
    m_err_ov = 1'b0; m_err_fr = 1'b0;
  endtask

  // Value of a complete frame as a weighted digit sum, applying the term budget if enabled.
  task automatic frame_value(output int val, output bit trunc);
    int kept = 0;
    val = 0; trunc = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (m_dq[i] != 0) begin
`ifdef HESE_ACC_TERM_BUDGET_EN
        if (kept >= MAX_TERMS) begin
          trunc = 1'b1;
          continue;
        end
`endif
        val += m_dq[i] * (1 << (DIGITS - 1 - i));
        kept++;
      end
    end
  endtask

  task automatic model_edge(input bit pw, input bit fs, input int d);
    bit cap = 1'b0, ov_evt = 1'b0, fr_evt = 1'b0, ct;
    int cv;
    if (pw) begin
      if (fs) begin
        if (m_in_frame) fr_evt = 1'b1;
        m_dq.delete();
        m_dq.push_back(d);
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        m_dq.push_back(d);
      end
      if (m_in_frame && m_dq.size() == DIGITS) begin
        frame_value(cv, ct);
        cap = 1'b1;
        m_in_frame = 1'b0;
      end
    end
    if (cap) begin
      if (!m_valid || rdy_v) begin
        m_data = cv; m_trunc = ct; m_valid = 1'b1;
      end else begin
        ov_evt = 1'b1;
      end
    end else if (m_valid && rdy_v) begin
      m_valid = 1'b0;
    end
    m_err_ov = ov_evt ? 1'b1 : (clr_v ? 1'b0 : m_err_ov);
    m_err_fr = fr_evt ? 1'b1 : (clr_v ? 1'b0 : m_err_fr);
  endtask

  task automatic compare_all();
    check_eq("out_valid", int'(out_valid), int'(m_valid));
    check_eq("out_data", int'(out_data), m_data);
    check_eq("out_truncated", int'(out_truncated), int'(m_trunc));
    check_eq("err_overflow", int'(err_overflow), int'(m_err_ov));
    check_eq("err_framing", int'(err_framing), int'(m_err_fr));
  endtask

  task automatic step(input bit pw, input bit fs, input int d);
    power_on    = pw;
    frame_start = fs;
    term_in     = (d != 0);
    sign_in     = (d < 0) ? 1'b1 : ((d == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
    out_ready   = rdy_v;
    err_clear   = clr_v;
    @(posedge clk);
    model_edge(pw, fs, d);
    #1;
    compare_all();
  endtask

  task automatic idle_gap();
    step(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)) - 1);
  endtask

  task automatic send_frame(input frame_t f, input int gap_max);
    for (int i = 0; i < DIGITS; i++) begin
      if (i > 0 && gap_max > 0) begin
        int g = $urandom_range(1, gap_max);
        for (int k = 0; k < g; k++) idle_gap();
      end
      step(1'b1, (i == 0), f[i]);
    end
  endtask

  task automatic pulse_reset(input string tag);
    reset = 1'b0;
    #2;
    check_eq({tag, "_data"}, int'(out_data), 0);
    check_eq({tag, "_valid"}, int'(out_valid), 0);
    check_eq({tag, "_trunc"}, int'(out_truncated), 0);
    check_eq({tag, "_ovf"}, int'(err_overflow), 0);
    check_eq({tag, "_frm"}, int'(err_framing), 0);
    model_reset();
    #1;
    reset = 1'b1;
  endtask

  initial begin
    frame_t f7, fmix, fneg1, fneg3;
    f7    = '{0, 0, 0, 0, 0, 1, 0, 0, -1};
    fmix  = '{1, -1, 1, -1, 0, 0, 0, 0, 0};
    fneg1 = '{0, 0, 0, 0, 0, 0, 0, -1, 1};
    fneg3 = '{0, 0, 0, 0, 0, 0, -1, 0, 1};

    power_on = 1'b0; frame_start = 1'b0; term_in = 1'b0; sign_in = 1'b0;
    out_ready = 1'b1; err_clear = 1'b0;
    reset = 1'b1;
    #2;
    pulse_reset("por");
    #4;

    // contiguous frame of 7
    send_frame(f7, 0);
    check_eq("f7_data", int'(out_data), 7);
    check_eq("f7_valid", int'(out_valid), 1);
    check_eq("f7_trunc", int'(out_truncated), 0);

    // budget frame
    send_frame(fmix, 0);
`ifdef HESE_ACC_TERM_BUDGET_EN
    check_eq("mix_data", int'(out_data), 128);
    check_eq("mix_trunc", int'(out_truncated), 1);
`else
    check_eq("mix_data", int'(out_data), 160);
    check_eq("mix_trunc", int'(out_truncated), 0);
`endif
    step(1'b0, 1'b0, 0);

    // overflow with consumer stalled
    rdy_v = 1'b0;
    send_frame(f7, 0);
    send_frame(fneg1, 0);
    check_eq("ovf_data", int'(out_data), 7);
    check_eq("ovf_flag", int'(err_overflow), 1);
    rdy_v = 1'b1;
    step(1'b0, 1'b0, 0);
    check_eq("ovf_drain", int'(out_valid), 0);
    clr_v = 1'b1;
    step(1'b0, 1'b0, 0);
    clr_v = 1'b0;
    check_eq("ovf_clear", int'(err_overflow), 0);

    // frame_start re-asserted at digit 4
    step(1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0);
    send_frame(fneg3, 0);
    check_eq("frm_flag", int'(err_framing), 1);
    check_eq("frm_data", int'(out_data), -3);

    // reset during digit 5, with state and flags populated
    rdy_v = 1'b0;
    send_frame(f7, 0);
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 1);
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b0, -1);
    power_on = 1'b1; term_in = 1'b1; sign_in = 1'b0;
    #2;
    pulse_reset("rst_mid");
    rdy_v = 1'b1;
    send_frame(f7, 0);
    check_eq("rst_after", int'(out_data), 7);
    step(1'b0, 1'b0, 0);

    // gaps with power_on=0
    send_frame(f7, 3);
    check_eq("gap_data", int'(out_data), 7);
    check_eq("gap_valid", int'(out_valid), 1);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      rdy_v = ($urandom_range(0, 3) != 0);
      clr_v = ($urandom_range(0, 15) == 0);
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), int'($urandom_range(0, 2)) - 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
